sm4_round_core: RTL and testbench
=================================

# sm4_round_core

Iterative SM4 cipher datapath that consumes the 32 round keys produced by `key_exps` and encrypts or decrypts one 128-bit block. It implements one round per clock (two with the unroll option) and sits between the key-expansion block and the system data path. Direction is set entirely by round-key order: `key_exps` presents keys already ordered for encryption or decryption, and this block always applies `rk_00` first.

## Interface
Parameters: none; the only build option is the macro under Configuration.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_exps_done`  in  1  round keys `rk_00`..`rk_31` are valid and stable while high.
- `rk_00` .. `rk_31`  in  32 each  round keys; `rk_i` is applied in round i.
- `data_valid`  in  1  `data_in` holds a block to process.
- `data_in`  in  128  input block, X0 = [127:96] .. X3 = [31:0].
- `data_ready`  out  1  block can be accepted. Combinational: `(state==IDLE) && key_exps_done`.
- `result_valid`  out  1  `data_out` holds a finished block.
- `result_ready`  in  1  downstream consumes the result.
- `data_out`  out  128  result block (X35, X34, X33, X32), MSW first.
- `busy`  out  1  high in ROUND or DONE.

## Operation
- **States.**
  - IDLE → ROUND on `data_valid && data_ready`: latch X0..X3 and clear `rnd` (5-bit) to 0.
  - ROUND: each clock computes X(i+4) = X(i) ^ T(X(i+1) ^ X(i+2) ^ X(i+3) ^ rk_i), with i = `rnd`, then shifts the window.
  - ROUND → DONE after round 31: `data_out` is loaded with the reversed window and `result_valid` is set.
  - DONE → IDLE on `result_ready`: `result_valid` clears.
- **T transform.** τ applies four parallel byte lookups into the standard SM4 S-box (GB/T 32907, 256×8, held in this block). L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24). All arithmetic is 32-bit XOR or rotate; there is no carry.
- **Key selection.** A 32:1 mux indexed by `rnd`; the counter wraps naturally from 31 to 0 on completion.
- **`key_exps_done` falls in ROUND.** Abort to IDLE and discard the partial state; `result_valid` stays 0.
- **`key_exps_done` falls in DONE.** The held result is still delivered.
- **`data_valid` while not ready.** Ignored; the block never accepts while `busy`.
- **`result_ready` high in IDLE or ROUND.** No effect.
- **Reset at any time.** Returns to IDLE immediately, and the in-flight block is lost.

## Timing
- **Reset values.**
  - `state` = IDLE, `rnd` = 0.
  - `result_valid` = 0, `busy` = 0, `data_out` = 0.
  - `data_ready` follows `key_exps_done`.
- **Latency.** With the accept edge N, rounds occur at edges N+1..N+32. `result_valid` is high after edge N+32, giving 32 cycles of latency.
- **Result hold.** `data_out` and `result_valid` are stable until the edge where `result_ready` = 1. `data_ready` re-asserts the cycle after that edge.
- **Throughput.** With `result_ready` tied high, one block every 34 cycles: accept, 32 rounds, 1 DONE cycle.
- **Keys.** `rk_*` are sampled combinationally in every round cycle. The upstream block must hold them constant while `key_exps_done` = 1.

## Configuration
- **`SM4_CORE_UNROLL2_EN` defined.**
  - Two cascaded round functions per clock, using `rk_{2j}` then `rk_{2j+1}`, with a 4-bit round counter.
  - Latency is 16 cycles (valid after edge N+16); throughput is 18 cycles per block.
  - Eight S-box lookups are instantiated.
- **Not defined.** Single-round datapath as described above (32-cycle latency, four S-box lookups).
- The interface and results are bit-identical in both builds.

## Test plan
- **Encrypt, standard vector.**
  - Stimulus: key 0123456789abcdeffedcba9876543210 expanded for encryption (`rk_00` = F12186F9, `rk_31` = 9124A012); `data_in` = 0123456789abcdeffedcba9876543210.
  - Required: `data_out` = 681edf34d206965e86b3e94f536e4246, `result_valid` high exactly 32 cycles after accept (16 with `SM4_CORE_UNROLL2_EN`).
- **Decrypt.**
  - Stimulus: same key with reversed key order; `data_in` = 681edf34d206965e86b3e94f536e4246.
  - Required: `data_out` = 0123456789abcdeffedcba9876543210.
- **Backpressure.**
  - Stimulus: hold `result_ready` = 0 for 10 cycles after `result_valid`.
  - Required: `data_out` stable, `data_ready` = 0, and a second `data_valid` is not accepted. `data_ready` = 1 the cycle after `result_ready` is raised.
- **Key loss mid-block.**
  - Stimulus: drop `key_exps_done` at round 15.
  - Required: the block returns to IDLE, `result_valid` never rises, and `busy` = 0 next cycle.
- **Async reset mid-block.**
  - Stimulus: assert `rst` between clock edges at round 20.
  - Required: `busy`, `result_valid` and `data_out` are 0 immediately. After release, a fresh encryption yields 681edf34d206965e86b3e94f536e4246.
- **Back-to-back.**
  - Stimulus: `data_valid` and `result_ready` held high; two plaintexts streamed (the standard vector, then all-zeros).
  - Required: accepts are 34 cycles apart, and both ciphertexts match a software reference.

Source files
------------

// File: rtl/sm4_round_core.sv
// Iterative SM4 round datapath: one round per clock, or two when SM4_CORE_UNROLL2_EN is defined.
// Round keys arrive pre-ordered, so the same engine encrypts or decrypts; rk_00 is always applied first.
module sm4_round_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_exps_done,
  input  logic [31:0]  rk_00, rk_01, rk_02, rk_03, rk_04, rk_05, rk_06, rk_07,
  input  logic [31:0]  rk_08, rk_09, rk_10, rk_11, rk_12, rk_13, rk_14, rk_15,
  input  logic [31:0]  rk_16, rk_17, rk_18, rk_19, rk_20, rk_21, rk_22, rk_23,
  input  logic [31:0]  rk_24, rk_25, rk_26, rk_27, rk_28, rk_29, rk_30, rk_31,
  input  logic         data_valid,
  input  logic [127:0] data_in,
  output logic         data_ready,
  output logic         result_valid,
  input  logic         result_ready,
  output logic [127:0] data_out,
  output logic         busy
);

`ifdef SM4_CORE_UNROLL2_EN
  localparam int RPC = 2;
`else
  localparam int RPC = 1;
`endif
  localparam int RND_W = (RPC == 2) ? 4 : 5;
  localparam logic [RND_W-1:0] RND_LAST = '1;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t             state_reg;
  logic [RND_W-1:0]   rnd_reg;
  logic [127:0]       win_reg;       // X(i)..X(i+3), X(i) in the top word
  logic [31:0][31:0]  rk_arr;
  logic [RPC:0][127:0] win;

  function automatic logic [31:0] sm4_l(input logic [31:0] b);
    return b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]}
             ^ {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  endfunction

  assign rk_arr = {rk_31, rk_30, rk_29, rk_28, rk_27, rk_26, rk_25, rk_24,
                   rk_23, rk_22, rk_21, rk_20, rk_19, rk_18, rk_17, rk_16,
                   rk_15, rk_14, rk_13, rk_12, rk_11, rk_10, rk_09, rk_08,
                   rk_07, rk_06, rk_05, rk_04, rk_03, rk_02, rk_01, rk_00};

  assign win[0] = win_reg;

  generate
    for (genvar gi = 0; gi < RPC; gi++) begin : g_round
      logic [4:0]  key_idx;
      logic [31:0] t_in;
      logic [31:0] sb_out;
      logic [31:0] x_new;

      assign key_idx = 5'(RPC * 32'(rnd_reg) + gi);
      assign t_in    = win[gi][95:64] ^ win[gi][63:32] ^ win[gi][31:0] ^ rk_arr[key_idx];

      for (genvar gj = 0; gj < 4; gj++) begin : g_sbox
        assign sb_out[8*gj +: 8] = SBOX[t_in[8*gj +: 8]];
      end

      assign x_new      = win[gi][127:96] ^ sm4_l(sb_out);
      assign win[gi+1]  = {win[gi][95:0], x_new};
    end
  endgenerate

  assign data_ready = (state_reg == IDLE) && key_exps_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      rnd_reg      <= '0;
      win_reg      <= '0;
      data_out     <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (data_valid && data_ready) begin
            win_reg   <= data_in;
            rnd_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= ROUND;
          end
        end
        ROUND: begin
          // Keys may be mid-update once done drops; the partial block is abandoned.
          if (!key_exps_done) begin
            rnd_reg   <= '0;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            win_reg <= win[RPC];
            rnd_reg <= rnd_reg + 1'b1;
            if (rnd_reg == RND_LAST) begin
              data_out     <= {win[RPC][31:0], win[RPC][63:32], win[RPC][95:64], win[RPC][127:96]};
              result_valid <= 1'b1;
              state_reg    <= DONE;
            end
          end
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state_reg    <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_round_core.sv
// Directed-plus-random bench for sm4_round_core against a software SM4 model
// (key schedule and cipher written from the algorithm definition).
module tb_sm4_round_core;

`ifdef SM4_CORE_UNROLL2_EN
  localparam int LAT = 16;
  localparam int PERIOD = 18;
  localparam int RST_AT = 10;
`else
  localparam int LAT = 32;
  localparam int PERIOD = 34;
  localparam int RST_AT = 20;
`endif

  localparam logic [127:0] STD_KEY = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_PT  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] STD_CT  = 128'h681edf34d206965e86b3e94f536e4246;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_exps_done = 1'b0;
  logic         data_valid = 1'b0;
  logic         result_ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [31:0]  rk [32];
  logic         data_ready, result_valid, busy;
  logic [127:0] data_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sm4_round_core dut (
    .clk(clk), .rst(rst), .key_exps_done(key_exps_done),
    .rk_00(rk[0]),  .rk_01(rk[1]),  .rk_02(rk[2]),  .rk_03(rk[3]),
    .rk_04(rk[4]),  .rk_05(rk[5]),  .rk_06(rk[6]),  .rk_07(rk[7]),
    .rk_08(rk[8]),  .rk_09(rk[9]),  .rk_10(rk[10]), .rk_11(rk[11]),
    .rk_12(rk[12]), .rk_13(rk[13]), .rk_14(rk[14]), .rk_15(rk[15]),
    .rk_16(rk[16]), .rk_17(rk[17]), .rk_18(rk[18]), .rk_19(rk[19]),
    .rk_20(rk[20]), .rk_21(rk[21]), .rk_22(rk[22]), .rk_23(rk[23]),
    .rk_24(rk[24]), .rk_25(rk[25]), .rk_26(rk[26]), .rk_27(rk[27]),
    .rk_28(rk[28]), .rk_29(rk[29]), .rk_30(rk[30]), .rk_31(rk[31]),
    .data_valid(data_valid), .data_in(data_in), .data_ready(data_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .data_out(data_out), .busy(busy)
  );

  // Reference model
  logic [7:0] sb [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };
  logic [31:0] enc_rk [32];

  function automatic logic [31:0] rol(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sb[x[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] x);
    logic [31:0] b;
    b = sub_word(x);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] x);
    logic [31:0] b;
    b = sub_word(x);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  task automatic expand_key(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck;
    fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4*i + j) * 7) % 256)};
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      enc_rk[i] = k[i+4];
    end
  endtask

  function automatic logic [127:0] model_crypt(input logic [127:0] blk, input bit dec);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = blk[127 - 32*i -: 32];
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ enc_rk[dec ? 31 - i : i]);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  task automatic load_keys(input bit dec);
    for (int i = 0; i < 32; i++) rk[i] = dec ? enc_rk[31 - i] : enc_rk[i];
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept one block, wait for its result, check latency/data, then consume it.
  task automatic run_block(input string tag, input logic [127:0] blk, input logic [127:0] exp);
    int cyc;
    cyc = 0;
    while (!data_ready && cyc < 100) begin @(negedge clk); cyc++; end
    check({tag, "_ready"}, 128'(data_ready), 128'd1);
    data_in = blk;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check({tag, "_busy"}, 128'(busy), 128'd1);
    cyc = 0;
    while (!result_valid && cyc < 100) begin @(negedge clk); cyc++; end
    check({tag, "_latency"}, 128'(cyc), 128'(LAT));
    check({tag, "_data"}, data_out, exp);
    $display("txn %s in=%h out=%h latency=%0d", tag, blk, data_out, cyc);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check({tag, "_release"}, 128'({result_valid, data_ready, busy}), 128'(3'b010));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] key, pt, ct, dout_hold;
    logic         seen;
    int           acc_cyc [$];
    logic [127:0] res [$];
    bit           acc;

    for (int i = 0; i < 32; i++) rk[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", 128'(result_valid), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    check("reset_dout", data_out, 128'd0);
    check("reset_ready_nokeys", 128'(data_ready), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    key_exps_done = 1'b1;
    #1;
    check("ready_follows_keys", 128'(data_ready), 128'd1);

    // Standard vector, both directions
    expand_key(STD_KEY);
    load_keys(1'b0);
    run_block("enc_std", STD_PT, STD_CT);
    load_keys(1'b1);
    run_block("dec_std", STD_CT, STD_PT);

    // Random keys and blocks against the model, plus round trip
    for (int r = 0; r < 3; r++) begin
      key = {$urandom(), $urandom(), $urandom(), $urandom()};
      pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
      expand_key(key);
      ct = model_crypt(pt, 1'b0);
      load_keys(1'b0);
      run_block("enc_rand", pt, ct);
      load_keys(1'b1);
      run_block("dec_rand", ct, pt);
    end

    // Backpressure: hold result for 10 cycles while a second block is offered
    expand_key(STD_KEY);
    load_keys(1'b0);
    data_in = STD_PT;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    for (int c = 0; c < 100 && !result_valid; c++) @(negedge clk);
    check("bp_valid", 128'(result_valid), 128'd1);
    dout_hold = data_out;
    data_in = 128'hdeadbeef_00112233_44556677_8899aabb;
    data_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_hold_data", data_out, STD_CT);
      check("bp_hold_ctl", 128'({result_valid, data_ready, busy}), 128'(3'b101));
    end
    check("bp_stable", data_out, dout_hold);
    data_valid = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("bp_release", 128'({result_valid, data_ready, busy}), 128'(3'b010));
    $display("txn backpressure out=%h", dout_hold);

    // Key loss with the round counter at 15
    data_in = STD_PT;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("keyloss_busy_before", 128'(busy), 128'd1);
    key_exps_done = 1'b0;
    @(negedge clk);
    check("keyloss_abort", 128'({busy, result_valid, data_ready}), 128'(3'b000));
    seen = 1'b0;
    repeat (40) begin @(negedge clk); seen = seen | result_valid | busy; end
    check("keyloss_quiet", 128'(seen), 128'd0);
    key_exps_done = 1'b1;
    $display("txn keyloss aborted");

    // Asynchronous reset between edges mid-block
    data_in = STD_PT;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (RST_AT) @(negedge clk);
    check("arst_busy_before", 128'(busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", 128'(busy), 128'd0);
    check("arst_valid", 128'(result_valid), 128'd0);
    check("arst_dout", data_out, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    $display("txn async_reset");
    run_block("enc_after_rst", STD_PT, STD_CT);

    // Back-to-back streaming with valid and ready held high
    data_in = STD_PT;
    data_valid = 1'b1;
    result_ready = 1'b1;
    for (int c = 0; c < 200 && res.size() < 2; c++) begin
      acc = data_valid && data_ready;
      if (result_valid) res.push_back(data_out);
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cyc.push_back(c);
        if (acc_cyc.size() == 1) data_in = '0;
        else data_valid = 1'b0;
      end
      @(negedge clk);
    end
    data_valid = 1'b0;
    result_ready = 1'b0;
    check("b2b_accepts", 128'(acc_cyc.size()), 128'd2);
    if (acc_cyc.size() == 2)
      check("b2b_spacing", 128'(acc_cyc[1] - acc_cyc[0]), 128'(PERIOD));
    check("b2b_results", 128'(res.size()), 128'd2);
    if (res.size() == 2) begin
      check("b2b_ct0", res[0], model_crypt(STD_PT, 1'b0));
      check("b2b_ct1", res[1], model_crypt(128'd0, 1'b0));
      $display("txn b2b out0=%h out1=%h", res[0], res[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
